mem_port_arbiter: RTL

//  Shares one single-port unified memory between the CPU instruction-fetch port and data port.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_fetch_age.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// FSM states, transaction owner and counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_fetch_age.sv
// Saturating fetch-age counter for the memory port arbiter.
// Counts consecutive fetch losses; at_max forces the next fetch win.
module arb_fetch_age
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int unsigned AW = cnt_w(MAX_WAIT);

    logic [AW-1:0] age_q;
    logic [AW-1:0] age_d;

    assign at_max_o = (age_q == AW'(MAX_WAIT));

    // Clear wins over increment; increment stops at MAX_WAIT.
    always_comb begin
        age_d = age_q;
        if (clr_i) begin
            age_d = '0;
        end else if (inc_i && !at_max_o) begin
            age_d = age_q + AW'(1);
        end
    end

    // Age register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-port unified memory.
// Data has priority; a fetch-age counter bounds fetch starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned CW = cnt_w(MEM_LAT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_owner_t        owner_q;
    arb_owner_t        owner_d;
    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] d_rdata_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    logic idle;
    logic at_max;
    logic fetch_win;
    logic if_gnt;
    logic d_gnt;
    logic age_inc;
    logic age_clr;

    // Grants only in IDLE; fetch wins alone or once it has aged out.
    assign idle      = (state_q == IDLE) && !rst_i;
    assign fetch_win = if_req_i && (!d_req_i || at_max);
    assign if_gnt    = idle && fetch_win;
    assign d_gnt     = idle && d_req_i && !fetch_win;
    assign age_inc   = idle && if_req_i && d_gnt;
    assign age_clr   = idle && (if_gnt || !if_req_i);

    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    arb_fetch_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (age_inc),
        .clr_i    (age_clr),
        .at_max_o (at_max)
    );

    // Next state, capture of the winning request and strobe decode.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (if_gnt || d_gnt) begin
                    state_d = ISSUE;
                    owner_d = if_gnt ? OWN_IF : OWN_D;
                    we_d    = d_gnt && d_we_i;
                    addr_d  = (if_gnt ? if_addr_i : d_addr_i) >> 2;
                    wdata_d = d_gnt ? d_wdata_i : '0;
                end
            end
            ISSUE: begin
                mem_en_o = 1'b1;
                mem_we_o = we_q;
                cnt_d    = CW'(MEM_LAT);
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if_rvalid_o = (owner_q == OWN_IF);
                d_rvalid_o  = (owner_q == OWN_D);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule
